// File: rtl/aer_pkg.sv
// Shared SRAM access types: address granularity of a memory word and its byte-address shift.
package aer_pkg;

    typedef enum logic [1:0] {
        SIZE_BT = 2'd0,
        SIZE_HW = 2'd1,
        SIZE_WD = 2'd2,
        SIZE_DW = 2'd3
    } size_e;

    function automatic int unsigned size_to_shift(size_e s);
        case (s)
            SIZE_BT: return 0;
            SIZE_HW: return 1;
            SIZE_WD: return 2;
            default: return 3;
        endcase
    endfunction

endpackage

// File: rtl/fwft_skid_buf.sv
// Two-entry first-word-fall-through output buffer (head + skid) fed by SRAM read returns.
module fwft_skid_buf #(
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              ret_i,
    input  logic [DWIDTH-1:0] ret_data_i,
    input  logic              pop_i,
    output logic              head_vld_o,
    output logic [DWIDTH-1:0] head_data_o,
    output logic [1:0]        occ_o
);

    logic              head_vld_q, head_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DWIDTH-1:0] head_data_q, head_data_d;
    logic [DWIDTH-1:0] skid_data_q, skid_data_d;

    always_comb begin
        head_vld_d  = head_vld_q;
        head_data_d = head_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (pop_i) begin
            head_vld_d  = skid_vld_q;
            head_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
        end
        // A return lands in the first slot left free after this cycle's pop.
        if (ret_i) begin
            if (!head_vld_d) begin
                head_vld_d  = 1'b1;
                head_data_d = ret_data_i;
            end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = ret_data_i;
            end
        end
        if (flush_i) begin
            head_vld_d  = 1'b0;
            head_data_d = '0;
            skid_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            head_data_q <= '0;
        end else begin
            head_vld_q  <= head_vld_d;
            skid_vld_q  <= skid_vld_d;
            head_data_q <= head_data_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

    assign head_vld_o  = head_vld_q;
    assign head_data_o = head_data_q;
    assign occ_o       = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: rtl/sram_prefetch_fifo.sv
// FIFO stored in an external 1W/1R SRAM, with a prefetch buffer so the head is always registered.
module sram_prefetch_fifo
    import aer_pkg::*;
#(
    parameter int    DWIDTH = 64,
    parameter int    DEPTH  = 64,
    parameter size_e SIZE   = SIZE_DW,
    localparam int AWIDTH     = $clog2(DEPTH),
    localparam int ADDR_SHIFT = int'(size_to_shift(SIZE)),
    localparam int SAW        = AWIDTH + ADDR_SHIFT,
    localparam int WMASK      = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_rst_n,
    input  logic              fifo_wr_en,
    input  logic [DWIDTH-1:0] fifo_wdata,
    input  logic              fifo_rd_en,
    output logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              fifo_almost_empty,
    output logic              fifo_almost_full,
    output logic [AWIDTH:0]   fifo_numel,
    input  logic [AWIDTH:0]   ae_thr,
    input  logic [AWIDTH:0]   af_thr,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
    output logic              ce_a,
    output logic              we_a,
    output logic [SAW-1:0]    addr_a,
    output logic [WMASK-1:0]  wmask_a,
    output logic [DWIDTH-1:0] wdata_a,
    output logic              ce_b,
    output logic [SAW-1:0]    addr_b,
    input  logic [DWIDTH-1:0] rdata_b,
    output logic              we_b,
    output logic [WMASK-1:0]  wmask_b,
    output logic [DWIDTH-1:0] wdata_b
);

    localparam int CW = AWIDTH + 1;

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d, unfetched;
    logic              inflight_q, inflight_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              flush, push, pop, head_vld, fetch;
    logic [1:0]        occ;
    logic [2:0]        pending;

    assign flush     = !fifo_rst_n;
    assign push      = fifo_wr_en && !fifo_full && !flush;
    assign pop       = fifo_rd_en && head_vld && !flush;
    assign unfetched = count_q - CW'(occ) - CW'(inflight_q);
    // Words held or promised to the buffer after this cycle's pop; never more than two.
    assign pending   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign fetch     = !flush && (unfetched != '0) && (pending < 3'd2);

    fwft_skid_buf #(.DWIDTH(DWIDTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .ret_i      (inflight_q && !flush),
        .ret_data_i (rdata_b),
        .pop_i      (pop),
        .head_vld_o (head_vld),
        .head_data_o(fifo_rdata),
        .occ_o      (occ)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inflight_d  = fetch;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        if (fetch) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        // A new error outranks a simultaneous clear.
        if (fifo_wr_en && fifo_full) overflow_d = 1'b1;
        else if (err_clr) overflow_d = 1'b0;
        if (fifo_rd_en && !head_vld) underflow_d = 1'b1;
        else if (err_clr) underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            inflight_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_numel        = count_q;
    assign fifo_empty        = !head_vld;
    assign fifo_full         = (count_q == CW'(DEPTH));
    assign fifo_almost_empty = (count_q <= ae_thr);
    assign fifo_almost_full  = (count_q >= af_thr);
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;

    assign ce_a    = push;
    assign we_a    = push;
    assign addr_a  = push ? (SAW'(wr_ptr_q) << ADDR_SHIFT) : '0;
    assign wmask_a = {WMASK{push}};
    assign wdata_a = push ? fifo_wdata : '0;

    assign ce_b    = fetch;
    assign addr_b  = fetch ? (SAW'(rd_ptr_q) << ADDR_SHIFT) : '0;
    assign we_b    = 1'b0;
    assign wmask_b = '0;
    assign wdata_b = '0;

endmodule

// File: tb/tb_sram_prefetch_fifo.sv
// Bench for sram_prefetch_fifo: directed scenarios plus random traffic against a queue model.
module tb_sram_prefetch_fifo;
    import aer_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int SAW   = 5;
    localparam int WM    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rst_n = 1'b1;
    logic          fifo_wr_en = 1'b0;
    logic [DW-1:0] fifo_wdata = '0;
    logic          fifo_rd_en = 1'b0;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty, fifo_full, fifo_almost_empty, fifo_almost_full;
    logic [AW:0]   fifo_numel;
    logic [AW:0]   ae_thr = 4'd1;
    logic [AW:0]   af_thr = 4'd6;
    logic          err_clr = 1'b0;
    logic          overflow, underflow;
    logic          ce_a, we_a, ce_b, we_b;
    logic [SAW-1:0] addr_a, addr_b;
    logic [WM-1:0] wmask_a, wmask_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic [DW-1:0] rdata_b = '0;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DW-1:0] mq[$];
    bit m_ovf = 0, m_unf = 0;
    int wr_idx = 0;

    always #5 clk = ~clk;

    sram_prefetch_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .SIZE(SIZE_WD)) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_rst_n(fifo_rst_n),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_almost_empty(fifo_almost_empty), .fifo_almost_full(fifo_almost_full),
        .fifo_numel(fifo_numel), .ae_thr(ae_thr), .af_thr(af_thr),
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
        .ce_a(ce_a), .we_a(we_a), .addr_a(addr_a), .wmask_a(wmask_a), .wdata_a(wdata_a),
        .ce_b(ce_b), .addr_b(addr_b), .rdata_b(rdata_b),
        .we_b(we_b), .wmask_b(wmask_b), .wdata_b(wdata_b)
    );

    // Word-addressed SRAM with one-cycle read latency; byte address >> 2 for 32-bit words.
    always @(posedge clk) begin
        if (ce_a && we_a) mem[addr_a[4:2]] <= wdata_a;
        if (ce_b) rdata_b <= mem[addr_b[4:2]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        int n;
        n = mq.size();
        chk("numel", 64'(fifo_numel), 64'(n));
        chk("full", 64'(fifo_full), 64'(n == DEPTH));
        chk("almost_empty", 64'(fifo_almost_empty), 64'(n <= int'(ae_thr)));
        chk("almost_full", 64'(fifo_almost_full), 64'(n >= int'(af_thr)));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("portb_tie", 64'({we_b, wmask_b, wdata_b}), 64'(0));
        if (!fifo_empty) begin
            chk("head_implies_data", 64'(n > 0), 64'(1));
            if (n > 0) chk("rdata", 64'(fifo_rdata), 64'(mq[0]));
        end
    endtask

    task automatic set_in(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr, input bit frst);
        fifo_wr_en = wr;
        fifo_wdata = d;
        fifo_rd_en = rd;
        err_clr    = clr;
        fifo_rst_n = frst;
    endtask

    // Called at a falling edge with inputs applied; advances one clock and checks the result.
    task automatic tick();
        bit flush, push_acc, pop_acc, empty_s, wr_s, rd_s, clr_s;
        logic [DW-1:0] d_s;
        #1;
        flush    = !fifo_rst_n;
        empty_s  = fifo_empty;
        wr_s     = fifo_wr_en;
        rd_s     = fifo_rd_en;
        clr_s    = err_clr;
        d_s      = fifo_wdata;
        push_acc = wr_s && (mq.size() < DEPTH) && !flush;
        pop_acc  = rd_s && !empty_s && !flush;
        chk("ce_a", 64'(ce_a), 64'(push_acc));
        chk("we_a", 64'(we_a), 64'(push_acc));
        if (push_acc) begin
            chk("addr_a", 64'(addr_a), 64'((wr_idx % DEPTH) * 4));
            chk("wmask_a", 64'(wmask_a), 64'hF);
            chk("wdata_a", 64'(wdata_a), 64'(d_s));
        end else begin
            chk("porta_idle", 64'({addr_a, wmask_a}), 64'(0));
        end
        @(posedge clk);
        if (flush) begin
            mq.delete();
            wr_idx = 0;
            m_ovf  = 0;
            m_unf  = 0;
        end else begin
            if (wr_s && mq.size() == DEPTH) m_ovf = 1;
            else if (clr_s) m_ovf = 0;
            if (rd_s && empty_s) m_unf = 1;
            else if (clr_s) m_unf = 0;
            if (pop_acc) void'(mq.pop_front());
            if (push_acc) begin
                mq.push_back(d_s);
                wr_idx++;
            end
        end
        cyc++;
        @(negedge clk);
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_empty", 64'(fifo_empty), 64'(1));
        chk("rst_almost_empty", 64'(fifo_almost_empty), 64'(1));
        chk("rst_full", 64'(fifo_full), 64'(0));
        chk("rst_ce", 64'({ce_a, ce_b}), 64'(0));
        chk("rst_numel", 64'(fifo_numel), 64'(0));
        chk("rst_rdata", 64'(fifo_rdata), 64'(0));
        compare();

        // First push into an empty FIFO appears two edges after its write edge.
        set_in(1, 32'hA1, 0, 0, 1); tick();
        set_in(0, '0, 0, 0, 1);     tick();
        chk("lat1_empty", 64'(fifo_empty), 64'(1));
        tick();
        chk("lat2_empty", 64'(fifo_empty), 64'(0));
        chk("lat2_rdata", 64'(fifo_rdata), 64'hA1);
        chk("lat2_numel", 64'(fifo_numel), 64'(1));
        set_in(0, '0, 1, 0, 1); tick();
        chk("pop1_empty", 64'(fifo_empty), 64'(1));

        // Flush, fill to full, then one push too many.
        set_in(0, '0, 0, 0, 0); tick();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 32'(i), 0, 0, 1);
            if (i == 3) begin
                #1;
                chk("addr_entry3", 64'(addr_a), 64'h0C);
            end
            tick();
        end
        set_in(1, 32'hFF, 0, 0, 1);
        #1;
        chk("ce_a_when_full", 64'(ce_a), 64'(0));
        tick();
        chk("ovf_full", 64'(fifo_full), 64'(1));
        chk("ovf_flag", 64'(overflow), 64'(1));
        chk("ovf_numel", 64'(fifo_numel), 64'(8));
        set_in(0, '0, 0, 1, 1); tick();
        chk("ovf_cleared", 64'(overflow), 64'(0));

        // Drain with read held: one word per cycle, in order.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, '0, 1, 0, 1);
            #1;
            chk("drain_valid", 64'(fifo_empty), 64'(0));
            chk("drain_data", 64'(fifo_rdata), 64'(i));
            tick();
        end
        chk("drain_done_empty", 64'(fifo_empty), 64'(1));
        set_in(0, '0, 1, 0, 1); tick();
        chk("unf_flag", 64'(underflow), 64'(1));
        set_in(0, '0, 0, 1, 1); tick();

        // Steady push+pop at occupancy 4 across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'(100 + i), 0, 0, 1); tick();
        end
        set_in(0, '0, 0, 0, 1);
        repeat (3) tick();
        for (int k = 0; k < 20; k++) begin
            set_in(1, 32'(104 + k), 1, 0, 1);
            #1;
            chk("conc_valid", 64'(fifo_empty), 64'(0));
            chk("conc_data", 64'(fifo_rdata), 64'(100 + k));
            tick();
            chk("conc_numel", 64'(fifo_numel), 64'(4));
        end

        // Flush while a read is in flight: its return must be dropped.
        set_in(0, '0, 0, 0, 0);         tick();
        set_in(1, 32'hBEEF, 0, 0, 1);   tick();
        set_in(0, '0, 0, 0, 1);
        #1;
        chk("fl_ce_b", 64'(ce_b), 64'(1));
        tick();
        set_in(0, '0, 0, 0, 0); tick();
        chk("fl_numel", 64'(fifo_numel), 64'(0));
        chk("fl_empty", 64'(fifo_empty), 64'(1));
        set_in(0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_stays_empty", 64'(fifo_empty), 64'(1));
        end
        set_in(1, 32'h55, 0, 0, 1); tick();
        set_in(0, '0, 0, 0, 1);     tick(); tick();
        chk("fl_new_data", 64'(fifo_rdata), 64'h55);

        // Random traffic.
        ae_thr = 4'($urandom_range(0, 8));
        af_thr = 4'($urandom_range(0, 8));
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                ae_thr = 4'($urandom_range(0, 8));
                af_thr = 4'($urandom_range(0, 8));
            end
            set_in(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 99) < 45),
                   bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 39) != 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
